// File: rtl/xbar_slave_port_sequencer_pkg.sv
// Shared encodings for the crossbar slave-port sequencer: FSM states, grant codes, commands.
package xbar_slave_port_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [1:0] GntNone = 2'b00;
  localparam logic [1:0] GntM0   = 2'b01;
  localparam logic [1:0] GntM1   = 2'b10;

  localparam logic CmdRead  = 1'b0;
  localparam logic CmdWrite = 1'b1;

  localparam int unsigned DefaultTimeout = 255;
  localparam int unsigned CntWidth       = 16;

endpackage

// File: rtl/xbar_rr_pick.sv
// Combinational 2-way round-robin picker; ptr=0 favours master0 on a tie, ptr=1 master1.
module xbar_rr_pick
  import xbar_slave_port_sequencer_pkg::*;
(
  input  logic       match0,
  input  logic       match1,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GntNone;
    if (match0 && match1) begin
      gnt = ptr ? GntM1 : GntM0;
    end else if (match0) begin
      gnt = GntM0;
    end else if (match1) begin
      gnt = GntM1;
    end
  end

endmodule

// File: rtl/xbar_slave_port_sequencer.sv
// Per-slave-port arbiter and sequencer: grants one master, holds slv_req until slv_ack or timeout,
// then returns a one-cycle ack (and err on timeout) with read data to the granted master.
module xbar_slave_port_sequencer
  import xbar_slave_port_sequencer_pkg::*;
#(
  parameter int unsigned N        = 31,
  parameter logic        SLAVE_ID = 1'b0,
  parameter int unsigned TIMEOUT  = DefaultTimeout
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [N:0]   addr0,
  input  logic [N:0]   addr1,
  input  logic         cmd0,
  input  logic         cmd1,
  input  logic [N:0]   wdata0,
  input  logic [N:0]   wdata1,
  input  logic         slv_ack,
  input  logic [N:0]   slv_rdata,
  output logic         slv_req,
  output logic [N:0]   slv_addr,
  output logic         slv_cmd,
  output logic [N:0]   slv_wdata,
  output logic         ack0,
  output logic         ack1,
  output logic         err0,
  output logic         err1,
  output logic [N:0]   rdata0,
  output logic [N:0]   rdata1,
  output logic [1:0]   gnt,
  output logic         busy
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);
  localparam logic [CntWidth-1:0] CntMax  = '1;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                slv_req_q, slv_req_d;
  logic [N:0]          slv_addr_q, slv_addr_d;
  logic                slv_cmd_q, slv_cmd_d;
  logic [N:0]          slv_wdata_q, slv_wdata_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [N:0]          rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                busy_q, busy_d;

  logic       match0, match1;
  logic [1:0] pick_gnt;
  logic       finish, timed_out;

  assign match0 = req0 & (addr0[N] == SLAVE_ID);
  assign match1 = req1 & (addr1[N] == SLAVE_ID);

  xbar_rr_pick u_rr_pick (
    .match0 (match0),
    .match1 (match1),
    .ptr    (ptr_q),
    .gnt    (pick_gnt)
  );

  // slv_ack has priority over the timeout on the same cycle.
  assign timed_out = !slv_ack && (cnt_q == CntLast);
  assign finish    = slv_ack || timed_out;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    slv_req_d   = slv_req_q;
    slv_addr_d  = slv_addr_q;
    slv_cmd_d   = slv_cmd_q;
    slv_wdata_d = slv_wdata_q;
    ack0_d      = ack0_q;
    ack1_d      = ack1_q;
    err0_d      = err0_q;
    err1_d      = err1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;

    unique case (state_q)
      StIdle: begin
        if (match0 || match1) begin
          if (pick_gnt == GntM1) begin
            slv_addr_d  = addr1;
            slv_cmd_d   = cmd1;
            slv_wdata_d = wdata1;
          end else begin
            slv_addr_d  = addr0;
            slv_cmd_d   = cmd0;
            slv_wdata_d = wdata0;
          end
          slv_req_d = 1'b1;
          gnt_d     = pick_gnt;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (finish) begin
          slv_req_d = 1'b0;
          if (gnt_q == GntM1) begin
            ack1_d = 1'b1;
            err1_d = timed_out;
            if (slv_ack && slv_cmd_q == CmdRead) rdata1_d = slv_rdata;
          end else begin
            ack0_d = 1'b1;
            err0_d = timed_out;
            if (slv_ack && slv_cmd_q == CmdRead) rdata0_d = slv_rdata;
          end
          // Next tie goes to the master that was not just served.
          ptr_d   = (gnt_q == GntM0);
          state_d = StDone;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        gnt_d   = GntNone;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      slv_req_q   <= 1'b0;
      slv_addr_q  <= '0;
      slv_cmd_q   <= 1'b0;
      slv_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      gnt_q       <= GntNone;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      slv_req_q   <= slv_req_d;
      slv_addr_q  <= slv_addr_d;
      slv_cmd_q   <= slv_cmd_d;
      slv_wdata_q <= slv_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
    end
  end

  assign slv_req   = slv_req_q;
  assign slv_addr  = slv_addr_q;
  assign slv_cmd   = slv_cmd_q;
  assign slv_wdata = slv_wdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;

endmodule
